acc_cpu_sequencer: RTL and testbench

Parametrised multi-cycle control sequencer for the accumulator computer. It replaces the fixed 3-bit step counter with a full fetch/decode/operand/execute/write state machine. It owns PC, IR, MAR, MBR and AC, and drives main memory through a req/ready handshake that tolerates wait states. Arithmetic is done by the existing combinational ALU, which connects through the alu_* ports using the ALU opcode encoding.

---
 rtl/acc_cpu_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_acc_cpu_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_cpu_sequencer.sv
// acc_cpu_sequencer: multi-cycle fetch/decode/operand/execute/write control
// sequencer for the accumulator computer. Owns PC, IR, MAR, MBR and AC and
// talks to memory over a req/ready handshake that tolerates wait states.
// Optional build macro: ACC_SEQ_INDIRECT_EN turns opcode E into LOADIND
// (AC <= M[M[MAR]]); without it opcode E is illegal and halts the machine.
module acc_cpu_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned OPC_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] acc,
  output logic [ADDR_W-1:0] pc,
  output logic              retire,
  output logic              halted,
  output logic              illegal
);

  localparam int unsigned IMM_W = DATA_W - OPC_W;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_OPER   = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [OPC_W-1:0] OP_NOP   = OPC_W'(4'h0);
  localparam logic [OPC_W-1:0] OP_LOAD  = OPC_W'(4'h1);
  localparam logic [OPC_W-1:0] OP_STORE = OPC_W'(4'h2);
  localparam logic [OPC_W-1:0] OP_ADD   = OPC_W'(4'h3);
  localparam logic [OPC_W-1:0] OP_SUB   = OPC_W'(4'h4);
  localparam logic [OPC_W-1:0] OP_AND   = OPC_W'(4'h5);
  localparam logic [OPC_W-1:0] OP_OR    = OPC_W'(4'h6);
  localparam logic [OPC_W-1:0] OP_XOR   = OPC_W'(4'h7);
  localparam logic [OPC_W-1:0] OP_JUMP  = OPC_W'(4'h8);
  localparam logic [OPC_W-1:0] OP_JZ    = OPC_W'(4'h9);
  localparam logic [OPC_W-1:0] OP_JNEG  = OPC_W'(4'hA);
  localparam logic [OPC_W-1:0] OP_LOADI = OPC_W'(4'hB);
  localparam logic [OPC_W-1:0] OP_SHL   = OPC_W'(4'hC);
  localparam logic [OPC_W-1:0] OP_SHR   = OPC_W'(4'hD);
`ifdef ACC_SEQ_INDIRECT_EN
  localparam logic [OPC_W-1:0] OP_LDIND = OPC_W'(4'hE);
`endif
  localparam logic [OPC_W-1:0] OP_HALT  = OPC_W'(4'hF);

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_SHL = 4'b0100;
  localparam logic [3:0] ALU_SHR = 4'b0101;
  localparam logic [3:0] ALU_AND = 4'b1000;
  localparam logic [3:0] ALU_OR  = 4'b1001;
  localparam logic [3:0] ALU_XOR = 4'b1010;

  logic [2:0]        state, state_nxt;
  logic [DATA_W-1:0] ir, ir_nxt;
  logic [ADDR_W-1:0] mar, mar_nxt;
  logic [DATA_W-1:0] mbr, mbr_nxt;
  logic [DATA_W-1:0] acc_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic              retire_nxt, halted_nxt, illegal_nxt;
  logic              fetch_open, fetch_open_nxt;
  logic              fetch_req;
  logic [OPC_W-1:0]  opc;
`ifdef ACC_SEQ_INDIRECT_EN
  logic              ind_stage, ind_stage_nxt;
`endif

  assign opc       = ir[DATA_W-1 -: OPC_W];
  assign mem_wdata = acc;
  assign alu_a     = acc;
  assign alu_b     = mbr;

  // Next-state, datapath updates and memory/ALU control per state
  always_comb begin
    state_nxt      = state;
    ir_nxt         = ir;
    mar_nxt        = mar;
    mbr_nxt        = mbr;
    acc_nxt        = acc;
    pc_nxt         = pc;
    retire_nxt     = 1'b0;
    halted_nxt     = halted;
    illegal_nxt    = illegal;
    fetch_open_nxt = 1'b0;
    fetch_req      = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = mar;
    alu_op         = ALU_ADD;
`ifdef ACC_SEQ_INDIRECT_EN
    ind_stage_nxt  = ind_stage;
`endif
    case (state)
      S_FETCH: begin
        // run only gates opening a request; an open one is held to completion
        fetch_req = run | fetch_open;
        mem_req   = fetch_req;
        mem_addr  = pc;
        if (fetch_req) begin
          if (mem_ready) begin
            ir_nxt    = mem_rdata;
            mar_nxt   = mem_rdata[ADDR_W-1:0];
            pc_nxt    = pc + ADDR_W'(1);
            state_nxt = S_DECODE;
          end else begin
            fetch_open_nxt = 1'b1;
          end
        end
      end
      S_DECODE: begin
        state_nxt  = S_FETCH;
        retire_nxt = 1'b1;
        case (opc)
          OP_NOP: begin
          end
          OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            state_nxt  = S_OPER;
            retire_nxt = 1'b0;
          end
          OP_STORE: begin
            state_nxt  = S_WRITE;
            retire_nxt = 1'b0;
          end
          OP_JUMP: pc_nxt = mar;
          OP_JZ:   if (acc == '0) pc_nxt = mar;
          OP_JNEG: if (acc[DATA_W-1]) pc_nxt = mar;
          OP_LOADI: acc_nxt = DATA_W'(ir[IMM_W-1:0]);
          OP_SHL: begin
            alu_op  = ALU_SHL;
            acc_nxt = alu_result;
          end
          OP_SHR: begin
            alu_op  = ALU_SHR;
            acc_nxt = alu_result;
          end
          OP_HALT: begin
            halted_nxt = 1'b1;
            state_nxt  = S_HALT;
          end
`ifdef ACC_SEQ_INDIRECT_EN
          OP_LDIND: begin
            state_nxt     = S_OPER;
            retire_nxt    = 1'b0;
            ind_stage_nxt = 1'b0;
          end
`endif
          default: begin
            illegal_nxt = 1'b1;
            halted_nxt  = 1'b1;
            state_nxt   = S_HALT;
            retire_nxt  = 1'b0;
          end
        endcase
      end
      S_OPER: begin
        mem_req  = 1'b1;
        mem_addr = mar;
        if (mem_ready) begin
`ifdef ACC_SEQ_INDIRECT_EN
          // first LOADIND read fetches the pointer and re-enters OPER
          if ((opc == OP_LDIND) && !ind_stage) begin
            mar_nxt       = mem_rdata[ADDR_W-1:0];
            ind_stage_nxt = 1'b1;
          end else begin
            mbr_nxt       = mem_rdata;
            ind_stage_nxt = 1'b0;
            state_nxt     = S_EXEC;
          end
`else
          mbr_nxt   = mem_rdata;
          state_nxt = S_EXEC;
`endif
        end
      end
      S_EXEC: begin
        state_nxt  = S_FETCH;
        retire_nxt = 1'b1;
        case (opc)
          OP_ADD: begin alu_op = ALU_ADD; acc_nxt = alu_result; end
          OP_SUB: begin alu_op = ALU_SUB; acc_nxt = alu_result; end
          OP_AND: begin alu_op = ALU_AND; acc_nxt = alu_result; end
          OP_OR:  begin alu_op = ALU_OR;  acc_nxt = alu_result; end
          OP_XOR: begin alu_op = ALU_XOR; acc_nxt = alu_result; end
          default: acc_nxt = mbr;
        endcase
      end
      S_WRITE: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = mar;
        if (mem_ready) begin
          retire_nxt = 1'b1;
          state_nxt  = S_FETCH;
        end
      end
      S_HALT: begin
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // State and architectural registers; synchronous reset clears everything
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_FETCH;
      ir         <= '0;
      mar        <= '0;
      mbr        <= '0;
      acc        <= '0;
      pc         <= '0;
      retire     <= 1'b0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
      fetch_open <= 1'b0;
`ifdef ACC_SEQ_INDIRECT_EN
      ind_stage  <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      ir         <= ir_nxt;
      mar        <= mar_nxt;
      mbr        <= mbr_nxt;
      acc        <= acc_nxt;
      pc         <= pc_nxt;
      retire     <= retire_nxt;
      halted     <= halted_nxt;
      illegal    <= illegal_nxt;
      fetch_open <= fetch_open_nxt;
`ifdef ACC_SEQ_INDIRECT_EN
      ind_stage  <= ind_stage_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_acc_cpu_sequencer.sv
// Testbench for acc_cpu_sequencer: behavioural memory with wait states,
// behavioural ALU, and an instruction-level reference model.
`timescale 1ns/1ps
module tb_acc_cpu_sequencer;

  logic        clock, reset, run;
  logic        mem_req, mem_we, mem_ready;
  logic [11:0] mem_addr, pc;
  logic [15:0] mem_wdata, mem_rdata, alu_a, alu_b, alu_result, acc;
  logic [3:0]  alu_op;
  logic        retire, halted, illegal;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] dmem [0:4095];
  logic [15:0] mmem [0:4095];
  int          waits = 0;
  bit          stall_en = 0;
  logic [11:0] stall_addr = 12'h000;
  int          stab_errs = 0;

  acc_cpu_sequencer #(.DATA_W(16), .ADDR_W(12), .OPC_W(4)) dut (
    .clock(clock), .reset(reset), .run(run),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .acc(acc), .pc(pc), .retire(retire), .halted(halted), .illegal(illegal)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Combinational ALU device
  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b1000: alu_result = alu_a & alu_b;
      4'b1001: alu_result = alu_a | alu_b;
      4'b1010: alu_result = alu_a ^ alu_b;
      4'b0100: alu_result = alu_a << 1;
      4'b0101: alu_result = alu_a >> 1;
      default: alu_result = 16'h0000;
    endcase
  end

  // Memory responder: `waits` wait cycles per request, checks request stability
  initial begin : responder
    bit          pending;
    int          cnt;
    logic [11:0] l_addr;
    logic        l_we;
    logic [15:0] l_wdata;
    pending = 0; cnt = 0; l_addr = '0; l_we = 0; l_wdata = '0;
    mem_ready = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(negedge clock);
      #1;
      if (mem_req === 1'b1) begin
        if (!pending) begin
          pending = 1; cnt = 0;
          l_addr = mem_addr; l_we = mem_we; l_wdata = mem_wdata;
        end else if (mem_addr !== l_addr || mem_we !== l_we || (l_we && mem_wdata !== l_wdata)) begin
          stab_errs++;
        end
        if (stall_en && mem_addr == stall_addr) begin
          mem_ready = 1'b0;
        end else if (cnt >= waits) begin
          mem_ready = 1'b1;
          mem_rdata = dmem[mem_addr];
          if (mem_we) dmem[mem_addr] = mem_wdata;
          pending = 0;
        end else begin
          mem_ready = 1'b0;
          cnt++;
        end
      end else begin
        mem_ready = 1'b0;
        pending = 0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) dmem[i] = 16'h0000;
  endtask

  task automatic sync_model();
    for (int i = 0; i < 4096; i++) mmem[i] = dmem[i];
  endtask

  // Leaves the bench at a falling edge with reset released and run=0
  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    run   = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Instruction-level reference: executes the ISA on mmem, counts cycles by rule
  task automatic model_run(input int w, output logic [15:0] ac, output logic [11:0] p,
                           output int ret, output int cyc, output bit hlt, output bit ill);
    logic [15:0] ir, opnd;
    logic [3:0]  op;
    logic [11:0] a;
    ac = 0; p = 0; ret = 0; cyc = 0; hlt = 0; ill = 0;
    for (int s = 0; s < 1000 && !hlt; s++) begin
      ir = mmem[p]; p = p + 12'd1; op = ir[15:12]; a = ir[11:0];
      cyc += 2 + w; ret++;
      opnd = mmem[a];
      case (op)
        4'h1: begin ac = opnd;      cyc += 2 + w; end
        4'h2: begin mmem[a] = ac;   cyc += 1 + w; end
        4'h3: begin ac = ac + opnd; cyc += 2 + w; end
        4'h4: begin ac = ac - opnd; cyc += 2 + w; end
        4'h5: begin ac = ac & opnd; cyc += 2 + w; end
        4'h6: begin ac = ac | opnd; cyc += 2 + w; end
        4'h7: begin ac = ac ^ opnd; cyc += 2 + w; end
        4'h8: p = a;
        4'h9: if (ac == 16'h0) p = a;
        4'hA: if (ac[15]) p = a;
        4'hB: ac = {4'h0, a};
        4'hC: ac = ac << 1;
        4'hD: ac = ac >> 1;
        4'hF: hlt = 1;
        4'hE: begin
`ifdef ACC_SEQ_INDIRECT_EN
          ac = mmem[opnd[11:0]]; cyc += 3 + 2 * w;
`else
          ill = 1; hlt = 1; ret--;
`endif
        end
        default: ;
      endcase
    end
  endtask

  // Runs until halted is seen, counting cycles and retire pulses
  task automatic run_dut(input int budget, output int cyc, output int ret, output bit to);
    cyc = 0; ret = 0; to = 1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      cyc++;
      if (retire) ret++;
      if (halted) begin to = 0; break; end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    repeat (3) @(negedge clock);
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    n_tests++; if (pc !== 12'h000) begin n_fail++; $display("FAIL reset_pc got %h exp 000", pc); end
    n_tests++; if (acc !== 16'h0000) begin n_fail++; $display("FAIL reset_acc got %h exp 0000", acc); end
    n_tests++; if ({halted, illegal, retire, mem_we} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got %b exp 0000", {halted, illegal, retire, mem_we}); end
    n_tests++; if (alu_op !== 4'b0000) begin n_fail++; $display("FAIL reset_alu_op got %b exp 0000", alu_op); end
  endtask

  task automatic test_program(input int w, input int exp_cyc);
    logic [15:0] m_ac; logic [11:0] m_pc; int m_ret, m_cyc, d_cyc, d_ret, e0; bit m_h, m_i, to;
    clear_mem();
    dmem[0] = 16'hB005; dmem[1] = 16'h3010; dmem[2] = 16'h2011; dmem[3] = 16'hF000;
    dmem[12'h010] = 16'h0007;
    sync_model();
    model_run(w, m_ac, m_pc, m_ret, m_cyc, m_h, m_i);
    waits = w; e0 = stab_errs;
    apply_reset();
    run = 1'b1;
    run_dut(500, d_cyc, d_ret, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL prog_timeout waits=%0d halted never set", w); end
    n_tests++; if (acc !== 16'h000C) begin n_fail++; $display("FAIL prog_acc waits=%0d got %h exp 000c", w, acc); end
    n_tests++; if (dmem[12'h011] !== 16'h000C) begin n_fail++; $display("FAIL prog_store waits=%0d got %h exp 000c", w, dmem[12'h011]); end
    n_tests++; if (d_ret != 4) begin n_fail++; $display("FAIL prog_retires waits=%0d got %0d exp 4", w, d_ret); end
    n_tests++; if (d_cyc != exp_cyc || d_cyc != m_cyc) begin
      n_fail++; $display("FAIL prog_cycles waits=%0d got %0d exp %0d", w, d_cyc, exp_cyc); end
    n_tests++; if (pc !== m_pc) begin n_fail++; $display("FAIL prog_pc waits=%0d got %h exp %h", w, pc, m_pc); end
    n_tests++; if (stab_errs != e0) begin n_fail++; $display("FAIL prog_stable waits=%0d got %0d changes exp 0", w, stab_errs - e0); end
    waits = 0;
  endtask

  // Loads a short program, runs k cycles, returns pc/acc
  task automatic run_k(input int k, output logic [11:0] p, output logic [15:0] a);
    apply_reset();
    run = 1'b1;
    repeat (k) @(negedge clock);
    p = pc; a = acc;
  endtask

  task automatic test_branches();
    logic [11:0] p; logic [15:0] a;
    clear_mem(); dmem[0] = 16'h9020;
    run_k(2, p, a);
    n_tests++; if (p !== 12'h020) begin n_fail++; $display("FAIL jz_taken got %h exp 020", p); end
    clear_mem(); dmem[0] = 16'hB001; dmem[1] = 16'h9020;
    run_k(4, p, a);
    n_tests++; if (p !== 12'h002) begin n_fail++; $display("FAIL jz_not_taken got %h exp 002", p); end
    clear_mem(); dmem[0] = 16'h1100; dmem[1] = 16'hA030; dmem[12'h100] = 16'h8000;
    run_k(6, p, a);
    n_tests++; if (p !== 12'h030) begin n_fail++; $display("FAIL jneg_taken got %h exp 030", p); end
    clear_mem(); dmem[0] = 16'hB001; dmem[1] = 16'hA030;
    run_k(4, p, a);
    n_tests++; if (p !== 12'h002) begin n_fail++; $display("FAIL jneg_not_taken got %h exp 002", p); end
  endtask

  task automatic test_boundaries();
    logic [11:0] p; logic [15:0] a;
    clear_mem(); dmem[0] = 16'h8FFF; dmem[12'hFFF] = 16'h0000;
    run_k(2, p, a);
    n_tests++; if (p !== 12'hFFF) begin n_fail++; $display("FAIL jump_top got %h exp fff", p); end
    @(negedge clock);
    n_tests++; if (pc !== 12'h000) begin n_fail++; $display("FAIL pc_wrap got %h exp 000", pc); end
    clear_mem(); dmem[0] = 16'hBFFF; dmem[1] = 16'hC000;
    run_k(4, p, a);
    n_tests++; if (a !== 16'h1FFE) begin n_fail++; $display("FAIL loadi_shl got %h exp 1ffe", a); end
    clear_mem(); dmem[0] = 16'hB000; dmem[1] = 16'h4100; dmem[12'h100] = 16'h0001;
    run_k(6, p, a);
    n_tests++; if (a !== 16'hFFFF) begin n_fail++; $display("FAIL sub_wrap got %h exp ffff", a); end
  endtask

  task automatic test_opcode_e();
    logic [11:0] p; logic [15:0] a; int reqs, rets;
`ifdef ACC_SEQ_INDIRECT_EN
    clear_mem(); dmem[0] = 16'hE030; dmem[12'h030] = 16'h0040; dmem[12'h040] = 16'hBEEF;
    run_k(4, p, a);
    n_tests++; if (a !== 16'h0000) begin n_fail++; $display("FAIL loadind_early got %h exp 0000", a); end
    @(negedge clock);
    n_tests++; if (acc !== 16'hBEEF) begin n_fail++; $display("FAIL loadind_acc got %h exp beef", acc); end
`else
    clear_mem(); dmem[0] = 16'hE000;
    run_k(2, p, a);
    n_tests++; if ({illegal, halted} !== 2'b11) begin
      n_fail++; $display("FAIL illegal_flags got %b exp 11", {illegal, halted}); end
    reqs = 0; rets = 0;
    repeat (20) begin @(negedge clock); if (mem_req) reqs++; if (retire) rets++; end
    n_tests++; if (reqs != 0 || rets != 0) begin
      n_fail++; $display("FAIL illegal_quiet got req=%0d retire=%0d exp 0 0", reqs, rets); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [11:0] p; logic [15:0] a; int reqs;
    clear_mem(); dmem[0] = 16'hB123; dmem[1] = 16'h1100; dmem[12'h100] = 16'h5555;
    stall_en = 1; stall_addr = 12'h100;
    run_k(6, p, a);
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 12'h100 || a !== 16'h0123) begin
      n_fail++; $display("FAIL oper_wait got req=%b addr=%h acc=%h exp 1 100 0123", mem_req, mem_addr, a); end
    reset = 1'b1; run = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    n_tests++; if (mem_req !== 1'b0 || pc !== 12'h000 || acc !== 16'h0000) begin
      n_fail++; $display("FAIL mid_reset got req=%b pc=%h acc=%h exp 0 000 0000", mem_req, pc, acc); end
    reqs = 0;
    repeat (5) begin @(negedge clock); if (mem_req) reqs++; end
    n_tests++; if (reqs != 0) begin n_fail++; $display("FAIL run0_idle got %0d request cycles exp 0", reqs); end
    run = 1'b1;
    #1;
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 12'h000 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL refetch got req=%b addr=%h we=%b exp 1 000 0", mem_req, mem_addr, mem_we); end
    stall_en = 0;
  endtask

  task automatic test_random();
    logic [15:0] m_ac; logic [11:0] m_pc; int m_ret, m_cyc, d_cyc, d_ret, n, mism, e0, w;
    bit m_h, m_i, to;
    logic [3:0] ops [0:13];
    logic [3:0] op; logic [11:0] fld;
    for (int i = 0; i < 14; i++) ops[i] = 4'(i);
    for (int it = 0; it < 25; it++) begin
      clear_mem();
      n = $urandom_range(4, 14);
      for (int i = 0; i < n - 1; i++) begin
        op = ops[$urandom_range(0, 13)];
        case (op)
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: fld = 12'h100 + 12'($urandom_range(0, 15));
          4'h8, 4'h9, 4'hA: fld = 12'($urandom_range(i + 1, n - 1));
          default: fld = 12'($urandom);
        endcase
        dmem[i] = {op, fld};
      end
      dmem[n - 1] = {4'hF, 12'($urandom)};
      for (int i = 12'h100; i < 12'h110; i++) dmem[i] = 16'($urandom);
      sync_model();
      w = $urandom_range(0, 2);
      model_run(w, m_ac, m_pc, m_ret, m_cyc, m_h, m_i);
      waits = w; e0 = stab_errs;
      apply_reset();
      run = 1'b1;
      run_dut(1000, d_cyc, d_ret, to);
      mism = 0;
      for (int i = 12'h100; i < 12'h110; i++) if (dmem[i] !== mmem[i]) mism++;
      n_tests++; if (to || acc !== m_ac || pc !== m_pc) begin
        n_fail++; $display("FAIL rand%0d_state got acc=%h pc=%h to=%b exp acc=%h pc=%h", it, acc, pc, to, m_ac, m_pc); end
      n_tests++; if (d_ret != m_ret || d_cyc != m_cyc) begin
        n_fail++; $display("FAIL rand%0d_timing got ret=%0d cyc=%0d exp ret=%0d cyc=%0d", it, d_ret, d_cyc, m_ret, m_cyc); end
      n_tests++; if (mism != 0 || stab_errs != e0) begin
        n_fail++; $display("FAIL rand%0d_mem got %0d word diffs %0d unstable exp 0 0", it, mism, stab_errs - e0); end
    end
    waits = 0;
  endtask

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    test_reset();
    test_program(0, 11);
    test_program(3, 29);
    test_branches();
    test_boundaries();
    test_opcode_e();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
